// File: rtl/counter_register.sv
// Generic enabled storage register: asynchronous active-low clear, loads D on clk when en=1.
// Used inside counter and standalone for data/valid latches.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q <= '0;
        end else if (en) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/counter.sv
// Synchronous up-counter with parallel load (load beats up), built on register.
// Optional simulation checks are enabled with the macro COUNTER_ASSERT_EN.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    input  logic             up,
    output logic [WIDTH-1:0] Q
);

    logic             en;
    logic [WIDTH-1:0] d_next;

    // Load takes priority; the increment wraps because the carry is dropped.
    assign en     = load | up;
    assign d_next = load ? D : Q + WIDTH'(1);

    register #(
        .WIDTH(WIDTH)
    ) u_register (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (d_next),
        .en    (en),
        .Q     (Q)
    );

`ifdef COUNTER_ASSERT_EN
    a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({load, up}))
        else $error("%m: load/up unknown");

    a_load: assert property (@(posedge clk) disable iff (!rst_n)
        load |=> (Q == $past(D)))
        else $error("%m: Q does not match loaded D");

    a_incr: assert property (@(posedge clk) disable iff (!rst_n)
        (!load && up) |=> (Q == $past(Q) + WIDTH'(1)))
        else $error("%m: Q did not increment");

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (!load && !up) |=> $stable(Q))
        else $error("%m: Q changed while idle");
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter (widths 1, 4, 6, 8) and the standalone register.
// Directed scenarios plus a randomized run against an arithmetic reference model.
module tb_counter;

    logic clk;
    logic rst_n;

    logic [3:0] d4;  logic load4; logic up4; logic [3:0] q4;
    logic [5:0] d6;  logic load6; logic up6; logic [5:0] q6;
    logic [7:0] d8;  logic load8; logic up8; logic [7:0] q8;
    logic [0:0] d1;  logic load1; logic up1; logic [0:0] q1;
    logic [1:0] rd;  logic ren;   logic [1:0] rq;

    int n_checks = 0;
    int n_fail   = 0;

    counter #(.WIDTH(4)) u_c4 (.clk(clk), .rst_n(rst_n), .D(d4), .load(load4), .up(up4), .Q(q4));
    counter #(.WIDTH(6)) u_c6 (.clk(clk), .rst_n(rst_n), .D(d6), .load(load6), .up(up6), .Q(q6));
    counter #(.WIDTH(8)) u_c8 (.clk(clk), .rst_n(rst_n), .D(d8), .load(load8), .up(up8), .Q(q8));
    counter #(.WIDTH(1)) u_c1 (.clk(clk), .rst_n(rst_n), .D(d1), .load(load1), .up(up1), .Q(q1));
    register #(.WIDTH(2)) u_r2 (.clk(clk), .rst_n(rst_n), .D(rd), .en(ren), .Q(rq));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp8;
    int exp4;

    initial begin
        rst_n = 1'b0;
        d4 = '0; load4 = 0; up4 = 0;
        d6 = '0; load6 = 0; up6 = 0;
        d8 = '0; load8 = 0; up8 = 0;
        d1 = '0; load1 = 0; up1 = 0;
        rd = '0; ren = 0;

        tick();
        chk("reset_q4", 32'(q4), 0);
        chk("reset_q6", 32'(q6), 0);
        chk("reset_q8", 32'(q8), 0);
        chk("reset_q1", 32'(q1), 0);
        chk("reset_reg", 32'(rq), 0);
        rst_n = 1'b1;

        // Scenario 1: async reset mid-count, synchronous resume
        d4 = 4'd9; load4 = 1;
        tick();
        chk("s1_load9", 32'(q4), 9);
        load4 = 0; up4 = 1;
        #2 rst_n = 1'b0;
        #1 chk("s1_async_clear", 32'(q4), 0);
        tick();
        chk("s1_held_in_reset", 32'(q4), 0);
        rst_n = 1'b1;
        tick();
        chk("s1_resume_1", 32'(q4), 1);
        tick();
        chk("s1_resume_2", 32'(q4), 2);

        // Scenario 2: 17 edges from 0 wrap through 15 -> 0 -> 1
        up4 = 0; d4 = 4'd0; load4 = 1;
        tick();
        load4 = 0; up4 = 1;
        exp4 = 0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            exp4 = (exp4 + 1) % 16;
            chk($sformatf("s2_count_%0d", i), 32'(q4), 32'(exp4));
        end
        up4 = 0;

        // Scenario 3: load beats up, then load, then hold
        d6 = 6'd5; load6 = 1;
        tick();
        chk("s3_pre5", 32'(q6), 5);
        d6 = 6'd0; load6 = 1; up6 = 1;
        tick();
        chk("s3_load_wins", 32'(q6), 0);
        d6 = 6'd33; up6 = 0;
        tick();
        chk("s3_load33", 32'(q6), 33);
        load6 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s3_hold33", 32'(q6), 33);
        end

        // Scenario 4: count to 200, hold 5 edges, resume
        d8 = 8'd190; load8 = 1;
        tick();
        load8 = 0; up8 = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("s4_reach200", 32'(q8), 200);
        up8 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s4_hold200", 32'(q8), 200);
        end
        up8 = 1;
        tick();
        chk("s4_resume201", 32'(q8), 201);
        up8 = 0;

        // Scenario 5: standalone register
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd = 2'b11; ren = 0;
        tick();
        chk("s5_en0_hold0", 32'(rq), 0);
        ren = 1;
        tick();
        chk("s5_en1_load3", 32'(rq), 3);
        rd = 2'b01; ren = 0;
        tick();
        chk("s5_en0_hold3", 32'(rq), 3);
        #2 rst_n = 1'b0;
        #1 chk("s5_async_clear", 32'(rq), 0);
        tick();
        rst_n = 1'b1;

        // Scenario 6: WIDTH=1 toggling and load-vs-up corner
        up1 = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("s6_toggle_%0d", i), 32'(q1), 32'(i % 2));
        end
        d1 = 1'b1; load1 = 1;
        tick();
        chk("s6_load_not_incr", 32'(q1), 1);
        load1 = 0; up1 = 0;

        // Randomized run on WIDTH=8 against the arithmetic model
        exp8 = int'(q8);
        for (int i = 0; i < 300; i++) begin
            load8 = ($urandom_range(0, 3) == 0);
            up8   = 1'($urandom_range(0, 1));
            d8    = 8'($urandom);
            tick();
            if (load8)    exp8 = int'(d8);
            else if (up8) exp8 = (exp8 + 1) % 256;
            chk($sformatf("rand_%0d", i), 32'(q8), 32'(exp8));
        end
        load8 = 0; up8 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
